mire_gen: RTL and testbench

//  Parametrised test-pattern generator: Wishbone master that writes a full HDISP x VDISP frame of 32-bit

---
 rtl/mire_gen_if.sv | 15 +
 rtl/mire_gen.sv | 188 ++++++++++++++++++
 tb/tb_mire_gen.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mire_gen_if.sv
// Wishbone classic bus bundle between the test-pattern generator and the SDRAM arbiter.
interface mire_gen_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;

  modport master (output cyc, stb, we, adr, dat_ms, sel, cti, bte, input ack);
  modport slave  (input cyc, stb, we, adr, dat_ms, sel, cti, bte, output ack);
endinterface

// File: rtl/mire_gen.sv
// Test-pattern generator: bursts full HDISP x VDISP frames of 0x00RRGGBB pixels into the
// framebuffer over Wishbone, releasing the bus for GAP cycles between tenures.
module mire_gen #(
  parameter int unsigned HDISP     = 800,
  parameter int unsigned VDISP     = 480,
  parameter logic [31:0] BASE_ADR  = 32'h0,
  parameter int unsigned GRID_LOG2 = 5,
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned GAP       = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              token,
  input  logic [1:0]        mode,
  input  logic [23:0]       solid_rgb,
  input  logic              scroll_en,
  output logic              frame_done,
  output logic [15:0]       frame_cnt,
  mire_gen_if.master        wshb_ifm
);

  localparam int unsigned X_W  = (HDISP > 2) ? $clog2(HDISP) : 1;
  localparam int unsigned Y_W  = (VDISP > 2) ? $clog2(VDISP) : 1;
  localparam int unsigned B_W  = (BURST_LEN > 2) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned G_W  = (GAP > 2) ? $clog2(GAP) : 1;
  localparam int unsigned XY_W = (X_W > Y_W) ? X_W : Y_W;
  localparam int unsigned E_W  = (XY_W > GRID_LOG2 + 1) ? XY_W : GRID_LOG2 + 1;

  localparam logic [X_W-1:0] X_LAST = X_W'(HDISP - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(VDISP - 1);
  localparam logic [B_W-1:0] B_LAST = B_W'(BURST_LEN - 1);
  localparam logic [G_W-1:0] G_LAST = G_W'(GAP - 1);
  localparam logic [E_W-1:0] G_MASK = E_W'((1 << GRID_LOG2) - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]     state, state_nxt;
  logic           stb_q;
  logic [31:0]    adr_q, adr_nxt;
  logic [31:0]    dat_q;
  logic [X_W-1:0] x, x_nxt, xs, xs_nxt, xoff, xoff_nxt;
  logic [Y_W-1:0] y, y_nxt;
  logic [B_W-1:0] beat;
  logic [G_W-1:0] gap_cnt;
  logic [1:0]     mode_q, mode_nxt;
  logic [23:0]    rgb_q, rgb_nxt;
  logic           scroll_q, scroll_nxt;
  logic           px_ack, frame_end;
  logic [23:0]    pix_nxt, bar_rgb;
  logic [2:0]     bar_idx;
  logic [E_W-1:0] xs_e, y_e;
  logic           grid_on, chk_on;

  assign wshb_ifm.stb    = stb_q;
  assign wshb_ifm.cyc    = stb_q;
  assign wshb_ifm.we     = stb_q;
  assign wshb_ifm.adr    = adr_q;
  assign wshb_ifm.dat_ms = dat_q;
  assign wshb_ifm.sel    = 4'hF;
  assign wshb_ifm.cti    = 3'b000;
  assign wshb_ifm.bte    = 2'b00;

  assign px_ack    = (state == S_BUS) && wshb_ifm.ack;
  assign frame_end = px_ack && (x == X_LAST) && (y == Y_LAST);

  // Bar i starts at the first xs with xs*8 >= i*HDISP.
  function automatic logic [31:0] bar_thr(input int unsigned k);
    return 32'((k * HDISP + 7) / 8);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Burst ends on beat count, token loss or frame boundary, always on an ack.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (token) state_nxt = S_BUS;
      S_BUS:  if (px_ack && (beat == B_LAST || !token || frame_end)) state_nxt = S_GAP;
      S_GAP:  if (gap_cnt == G_LAST) state_nxt = token ? S_BUS : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next pixel position, scroll offset and per-frame latches.
  always_comb begin
    x_nxt      = x;
    y_nxt      = y;
    xs_nxt     = xs;
    xoff_nxt   = xoff;
    adr_nxt    = adr_q;
    mode_nxt   = mode_q;
    rgb_nxt    = rgb_q;
    scroll_nxt = scroll_q;
    if (px_ack) begin
      adr_nxt = adr_q + 32'd4;
      if (x == X_LAST) begin
        x_nxt  = '0;
        xs_nxt = xoff;
        if (y == Y_LAST) begin
          y_nxt      = '0;
          adr_nxt    = BASE_ADR;
          xoff_nxt   = !scroll_q ? xoff : (xoff == X_LAST) ? '0 : xoff + X_W'(1);
          xs_nxt     = xoff_nxt;
          mode_nxt   = mode;
          rgb_nxt    = solid_rgb;
          scroll_nxt = scroll_en;
        end else begin
          y_nxt = y + Y_W'(1);
        end
      end else begin
        x_nxt  = x + X_W'(1);
        xs_nxt = (xs == X_LAST) ? '0 : xs + X_W'(1);
      end
    end else if (state == S_IDLE && x == '0 && y == '0) begin
      mode_nxt   = mode;
      rgb_nxt    = solid_rgb;
      scroll_nxt = scroll_en;
    end
  end

  // Pattern of the pixel that will be on the bus next cycle.
  always_comb begin
    xs_e    = E_W'(xs_nxt);
    y_e     = E_W'(y_nxt);
    grid_on = ((xs_e & G_MASK) == '0) || ((y_e & G_MASK) == '0);
    chk_on  = |(((xs_e ^ y_e) >> GRID_LOG2) & E_W'(1));
    bar_idx = 3'd0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (32'(xs_nxt) >= bar_thr(k)) bar_idx = 3'(k);
    end
    case (bar_idx)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
    case (mode_nxt)
      2'd0:    pix_nxt = grid_on ? 24'h000000 : 24'hFFFFFF;
      2'd1:    pix_nxt = bar_rgb;
      2'd2:    pix_nxt = chk_on ? 24'hFFFFFF : 24'h000000;
      default: pix_nxt = rgb_nxt;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stb_q      <= 1'b0;
      adr_q      <= BASE_ADR;
      dat_q      <= 32'h0;
      x          <= '0;
      y          <= '0;
      xs         <= '0;
      xoff       <= '0;
      beat       <= '0;
      gap_cnt    <= '0;
      mode_q     <= 2'd0;
      rgb_q      <= 24'h0;
      scroll_q   <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= 16'h0;
    end else begin
      stb_q      <= (state_nxt == S_BUS);
      adr_q      <= adr_nxt;
      dat_q      <= {8'h00, pix_nxt};
      x          <= x_nxt;
      y          <= y_nxt;
      xs         <= xs_nxt;
      xoff       <= xoff_nxt;
      mode_q     <= mode_nxt;
      rgb_q      <= rgb_nxt;
      scroll_q   <= scroll_nxt;
      beat       <= (state_nxt != S_BUS) ? '0 : px_ack ? beat + B_W'(1) : beat;
      gap_cnt    <= (state == S_GAP && state_nxt == S_GAP) ? gap_cnt + G_W'(1) : '0;
      frame_done <= frame_end;
      frame_cnt  <= frame_cnt + 16'(frame_end);
    end
  end

endmodule

// File: tb/tb_mire_gen.sv
// Directed bench for mire_gen: a small 8x4 instance for bus timing/reset and a 16x8 instance
// for patterns, per-frame latching and scroll.
module tb_mire_gen;
  logic        clk = 1'b0;
  logic        rst_a, rst_b, tok_a, tok_b, scr_a, scr_b, fd_a, fd_b;
  logic [1:0]  mode_a, mode_b;
  logic [23:0] rgb_a, rgb_b;
  logic [15:0] fc_a, fc_b;
  int          n_cmp = 0;
  int          n_err = 0;

  mire_gen_if a_if();
  mire_gen_if b_if();

  mire_gen #(.HDISP(8), .VDISP(4), .BASE_ADR(32'h0), .GRID_LOG2(2), .BURST_LEN(4), .GAP(1)) u_a (
    .clk(clk), .rst(rst_a), .token(tok_a), .mode(mode_a), .solid_rgb(rgb_a), .scroll_en(scr_a),
    .frame_done(fd_a), .frame_cnt(fc_a), .wshb_ifm(a_if));

  mire_gen #(.HDISP(16), .VDISP(8), .BASE_ADR(32'h0), .GRID_LOG2(2), .BURST_LEN(16), .GAP(2)) u_b (
    .clk(clk), .rst(rst_b), .token(tok_b), .mode(mode_b), .solid_rgb(rgb_b), .scroll_en(scr_b),
    .frame_done(fd_b), .frame_cnt(fc_b), .wshb_ifm(b_if));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] grid_px(input int x, input int y);
    return (((x % 4) == 0) || ((y % 4) == 0)) ? 32'h0 : 32'h00FFFFFF;
  endfunction

  // Instance A: record acked addresses, stb trace and frame_done pulses.
  bit          mon_a = 1'b0;
  logic [31:0] a_adr [$];
  bit          a_stb [$];
  int          nd_a = 0;
  logic [15:0] fc_first = 16'hFFFF;
  always @(negedge clk) begin
    if (mon_a) begin
      if ((a_if.stb || a_stb.size() != 0) && a_stb.size() < 40) a_stb.push_back(a_if.stb);
      if (a_if.stb && a_if.ack) a_adr.push_back(a_if.adr);
      if (fd_a) begin
        if (nd_a == 0) fc_first = fc_a;
        nd_a++;
      end
    end
  end

  // Instance B: capture written frames pixel by pixel.
  logic [31:0] pix_b [6][128];
  int          fr_b = 0;
  int          cif_b = 0;
  always @(negedge clk) begin
    if (rst_b) begin
      fr_b  = 0;
      cif_b = 0;
    end else if (b_if.stb && b_if.ack) begin
      if (fr_b < 6) pix_b[fr_b][b_if.adr[8:2]] = b_if.dat_ms;
      cif_b++;
      if (b_if.adr[8:2] == 7'd127) begin
        fr_b++;
        cif_b = 0;
      end
    end
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; tok_a = 1'b1; tok_b = 1'b1;
    mode_a = 2'd0; mode_b = 2'd0; rgb_a = 24'h0; rgb_b = 24'h0; scr_a = 1'b0; scr_b = 1'b0;
    a_if.ack = 1'b1; b_if.ack = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_stb", 32'(a_if.stb), 32'd0);
    chk("rst_cyc", 32'(a_if.cyc), 32'd0);
    chk("rst_we", 32'(a_if.we), 32'd0);
    chk("rst_adr", a_if.adr, 32'h0);
    chk("rst_fd", 32'(fd_a), 32'd0);
    chk("rst_fc", 32'(fc_a), 32'd0);
    chk("sel", 32'(a_if.sel), 32'hF);
    chk("cti", 32'(a_if.cti), 32'd0);
    chk("bte", 32'(a_if.bte), 32'd0);

    // Continuous ack: 4-beat bursts, one idle cycle, address ramp wrapping per frame.
    mon_a = 1'b1;
    @(posedge clk); #1 rst_a = 1'b0;
    for (int i = 0; i < 1000 && a_adr.size() < 66; i++) @(negedge clk);
    mon_a = 1'b0;
    chk("t1_ack_count", 32'(a_adr.size() >= 66), 32'd1);
    for (int i = 0; i < 66 && i < a_adr.size(); i++)
      chk($sformatf("t1_adr%0d", i), a_adr[i], 32'((i % 32) * 4));
    for (int i = 0; i < 20 && i < a_stb.size(); i++)
      chk($sformatf("t1_stb%0d", i), 32'(a_stb[i]), 32'((i % 5) != 4));
    chk("t1_fc_first", 32'(fc_first), 32'd1);
    chk("t1_fd_pulses", 32'(nd_a), 32'd2);

    // Delayed ack with token dropped while waiting.
    rst_a = 1'b1; a_if.ack = 1'b0; tok_a = 1'b1; mode_a = 2'd3; rgb_a = 24'hABCDEF;
    @(negedge clk); @(posedge clk); #1 rst_a = 1'b0;
    for (int i = 0; i < 20 && !a_if.stb; i++) @(negedge clk);
    chk("t4_stb", 32'(a_if.stb), 32'd1);
    chk("t4_adr", a_if.adr, 32'h0);
    chk("t4_dat", a_if.dat_ms, 32'h00ABCDEF);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i == 0) tok_a = 1'b0;
      @(negedge clk);
      chk($sformatf("t4_hold_stb%0d", i), 32'(a_if.stb), 32'd1);
      chk($sformatf("t4_hold_adr%0d", i), a_if.adr, 32'h0);
      chk($sformatf("t4_hold_dat%0d", i), a_if.dat_ms, 32'h00ABCDEF);
    end
    @(posedge clk); #1 a_if.ack = 1'b1;
    @(posedge clk); #1 a_if.ack = 1'b0;
    @(negedge clk);
    chk("t4_stb_drop", 32'(a_if.stb), 32'd0);
    chk("t4_adr_next", a_if.adr, 32'h4);
    repeat (3) @(negedge clk);
    chk("t4_parked", 32'(a_if.stb), 32'd0);
    @(posedge clk); #1 tok_a = 1'b1;
    for (int i = 0; i < 5 && !a_if.stb; i++) @(negedge clk);
    chk("t4_resume_stb", 32'(a_if.stb), 32'd1);
    chk("t4_resume_adr", a_if.adr, 32'h4);

    // Asynchronous reset while a write is pending.
    mode_a = 2'd0; a_if.ack = 1'b1;
    for (int i = 0; i < 200 && fc_a == 16'd0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 a_if.ack = 1'b0;
    for (int i = 0; i < 10 && !a_if.stb; i++) @(negedge clk);
    chk("t6_pre_stb", 32'(a_if.stb), 32'd1);
    chk("t6_pre_adr_nz", 32'(a_if.adr != 32'h0), 32'd1);
    chk("t6_pre_fc", 32'(fc_a), 32'd1);
    @(posedge clk); #3 rst_a = 1'b1; #1;
    chk("t6_stb", 32'(a_if.stb), 32'd0);
    chk("t6_cyc", 32'(a_if.cyc), 32'd0);
    chk("t6_fc", 32'(fc_a), 32'd0);
    chk("t6_adr", a_if.adr, 32'h0);
    @(negedge clk); @(posedge clk); #1 rst_a = 1'b0; a_if.ack = 1'b1;
    for (int i = 0; i < 10 && !a_if.stb; i++) @(negedge clk);
    chk("t6_restart_stb", 32'(a_if.stb), 32'd1);
    chk("t6_restart_adr", a_if.adr, 32'h0);
    rst_a = 1'b1;

    // Instance B: grid -> checker -> bars -> solid, each change made mid-frame.
    @(posedge clk); #1 rst_b = 1'b0;
    for (int i = 0; i < 3000 && !(fr_b == 0 && cif_b >= 40); i++) @(negedge clk);
    chk("tmo_f0", 32'(fr_b == 0 && cif_b >= 40), 32'd1);
    mode_b = 2'd2;
    for (int i = 0; i < 3000 && !(fr_b == 1 && cif_b >= 40); i++) @(negedge clk);
    chk("tmo_f1", 32'(fr_b == 1 && cif_b >= 40), 32'd1);
    mode_b = 2'd1;
    for (int i = 0; i < 3000 && !(fr_b == 2 && cif_b >= 40); i++) @(negedge clk);
    chk("tmo_f2", 32'(fr_b == 2 && cif_b >= 40), 32'd1);
    mode_b = 2'd3; rgb_b = 24'h123456;
    for (int i = 0; i < 3000 && fr_b < 4; i++) @(negedge clk);
    chk("tmo_f3", 32'(fr_b >= 4), 32'd1);
    chk("grid_0_1", pix_b[0][16], 32'h0);
    chk("grid_1_1", pix_b[0][17], 32'h00FFFFFF);
    chk("grid_4_2", pix_b[0][36], 32'h0);
    chk("grid_5_5_late", pix_b[0][85], 32'h00FFFFFF);
    chk("chk_4_0", pix_b[1][4], 32'h00FFFFFF);
    chk("chk_4_4", pix_b[1][68], 32'h0);
    chk("chk_5_5", pix_b[1][85], 32'h0);
    chk("bar_x0", pix_b[2][0], 32'h00FFFFFF);
    chk("bar_x1", pix_b[2][1], 32'h00FFFFFF);
    chk("bar_x2", pix_b[2][2], 32'h00FFFF00);
    chk("bar_x8", pix_b[2][8], 32'h00FF00FF);
    chk("bar_x15", pix_b[2][15], 32'h0);
    for (int i = 0; i < 128; i++) chk($sformatf("solid%0d", i), pix_b[3][i], 32'h00123456);

    // Scroll: frame 2 is frame 1 shifted left by one pixel.
    rst_b = 1'b1; mode_b = 2'd0; scr_b = 1'b1;
    @(negedge clk); @(posedge clk); #1 rst_b = 1'b0;
    for (int i = 0; i < 3000 && fr_b < 2; i++) @(negedge clk);
    chk("tmo_scroll", 32'(fr_b >= 2), 32'd1);
    for (int x = 0; x < 16; x++) begin
      chk($sformatf("scr_f1_x%0d", x), pix_b[0][16 + x], grid_px(x, 1));
      chk($sformatf("scr_f2_x%0d", x), pix_b[1][16 + x], grid_px((x + 1) % 16, 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
